// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, parity selectors and
// the bit-vote helper used by the receive sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit tick counter and 3-point mid-bit sampler; presents the majority
// vote together with a strobe on the last tick of every bit period.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic rx,
  output logic vote,
  output logic bit_end
);

  localparam int EW = $clog2(OVERSAMPLE);

  logic [EW-1:0] edge_cnt;
  logic [2:0]    smp;

  // NOTE: every register here is written with <= so all flops update
  // from the same pre-edge values; blocking writes would create ordering races.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      smp      <= '0;
    end else if (clr) begin
      // While idle the low level seen this cycle is tick 0 of the start bit,
      // so the next cycle is already tick 1.
      edge_cnt <= rx ? '0 : EW'(1);
      smp      <= '0;
    end else begin
      if (edge_cnt == EW'(OVERSAMPLE - 1)) edge_cnt <= '0;
      else                                 edge_cnt <= edge_cnt + 1'b1;

      if (edge_cnt == EW'(OVERSAMPLE/2 - 1)) smp[0] <= rx;
      if (edge_cnt == EW'(OVERSAMPLE/2))     smp[1] <= rx;
      if (edge_cnt == EW'(OVERSAMPLE/2 + 1)) smp[2] <= rx;
    end
  end

  assign vote    = majority3(smp[0], smp[1], smp[2]);
  assign bit_end = !clr && (edge_cnt == EW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start validation, LSB-first deserialisation,
// optional parity and stop checking, registered word and status strobes.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             Data_Valid,
  output logic             par_err,
  output logic             stp_err,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_e        state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH:0]   shift_cat;
  logic             par_en_q;
  logic             par_typ_q;
  logic             par_flag;
  logic             vote;
  logic             bit_end;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (state == IDLE),
    .rx      (RX_IN),
    .vote    (vote),
    .bit_end (bit_end)
  );

  // New bit enters at the MSB end; after WIDTH bits the first one is at bit 0.
  assign shift_cat = {vote, shift_reg};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_flag   <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and are raised only by the
      // frame-end branch, which makes them single-cycle pulses by construction.
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state     <= START;
            Busy      <= 1'b1;
            bit_cnt   <= '0;
            par_flag  <= 1'b0;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
          end
        end

        START: begin
          if (bit_end) begin
            if (vote) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_cat[WIDTH:1];
            if (bit_cnt == CW'(WIDTH - 1)) state <= par_en_q ? PARITY : STOP;
            else                           bit_cnt <= bit_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            par_flag <= vote != ((^shift_reg) ^ (par_typ_q == PAR_ODD));
            state    <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (!par_flag && vote) begin
              P_DATA     <= shift_reg;
              Data_Valid <= 1'b1;
            end else begin
              par_err <= par_flag;
              stp_err <= ~vote;
            end
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a frame-level model predicts every output
// for every cycle from the driven line levels; a monitor compares each cycle.
module tb_uart_rx_frame;

  localparam int WIDTH = 8;
  localparam int OS    = 8;
  localparam int MAXC  = 4096;

  logic             CLK = 1'b0;
  logic             RST;
  logic             RX_IN;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             par_err;
  logic             stp_err;
  logic             Busy;

  always #5 CLK = ~CLK;

  uart_rx_frame #(.WIDTH(WIDTH), .OVERSAMPLE(OS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .Busy       (Busy)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected value of every output in every cycle.
  bit               busy_exp [MAXC];
  bit               dv_exp   [MAXC];
  bit               pe_exp   [MAXC];
  bit               se_exp   [MAXC];
  logic [WIDTH-1:0] pd_exp   [MAXC];

  int n_vec  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  bit line_q[$];
  bit cur_par_en;
  bit cur_par_typ;

  int last_dv_cyc   = -1;
  int last_pe_cyc   = -1;
  int last_se_cyc   = -1;
  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  int dv_q[$];
  bit prev_busy     = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (run) begin
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget: got %0d expected < %0d", cyc, MAXC);
        $fatal(1);
      end
      check("busy",       32'(Busy),       32'(busy_exp[cyc]));
      check("data_valid", 32'(Data_Valid), 32'(dv_exp[cyc]));
      check("par_err",    32'(par_err),    32'(pe_exp[cyc]));
      check("stp_err",    32'(stp_err),    32'(se_exp[cyc]));
      check("p_data",     32'(P_DATA),     32'(pd_exp[cyc]));
      if (Data_Valid === 1'b1) begin
        last_dv_cyc = cyc;
        dv_q.push_back(cyc);
      end
      if (par_err === 1'b1) last_pe_cyc = cyc;
      if (stp_err === 1'b1) last_se_cyc = cyc;
      if (!prev_busy && Busy === 1'b1) busy_rise_cyc = cyc;
      if (prev_busy && Busy === 1'b0)  busy_fall_cyc = cyc;
      prev_busy = (Busy === 1'b1);
    end
  end

  // Line image of one frame: start, data LSB first, optional parity, stop.
  // With glitch set, tick OS/2 of every bit carries the inverted level.
  task automatic build(input logic [7:0] d, input bit pen, input bit pbit,
                       input bit stop, input bit glitch);
    bit bits[$];
    line_q.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stop);
    foreach (bits[j])
      for (int k = 0; k < OS; k++)
        line_q.push_back((glitch && k == OS/2) ? !bits[j] : bits[j]);
  endtask

  // Frame-level prediction from the line image that starts in cycle t0.
  task automatic model_frame(input int t0);
    int         nb, n, len, ones;
    bit         v[16];
    bit         ok_par, ok_stop;
    logic [7:0] w;
    nb = line_q.size() / OS;
    for (int j = 0; j < nb && j < 16; j++)
      v[j] = (int'(line_q[j*OS + OS/2 - 1]) + int'(line_q[j*OS + OS/2]) +
              int'(line_q[j*OS + OS/2 + 1])) >= 2;
    if (v[0]) begin
      for (int c = t0 + 1; c < t0 + OS; c++) busy_exp[c] = 1'b1;
      return;
    end
    n   = WIDTH + 2 + (cur_par_en ? 1 : 0);
    len = n * OS;
    w    = '0;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      w[i] = v[1 + i];
      ones += int'(v[1 + i]);
    end
    ok_par = 1'b1;
    if (cur_par_en) ok_par = ((ones + int'(v[WIDTH + 1])) % 2) == (cur_par_typ ? 1 : 0);
    ok_stop = v[n - 1];
    for (int c = t0 + 1; c < t0 + len; c++) busy_exp[c] = 1'b1;
    if (ok_par && ok_stop) begin
      dv_exp[t0 + len] = 1'b1;
      for (int c = t0 + len; c < MAXC; c++) pd_exp[c] = w;
    end else begin
      pe_exp[t0 + len] = !ok_par;
      se_exp[t0 + len] = !ok_stop;
    end
  endtask

  task automatic model_reset(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      busy_exp[c] = 1'b0;
      dv_exp[c]   = 1'b0;
      pe_exp[c]   = 1'b0;
      se_exp[c]   = 1'b0;
      pd_exp[c]   = '0;
    end
  endtask

  // Drives up to n_drive ticks of line_q, one per cycle, starting next cycle.
  task automatic send(input bit pen, input bit ptyp, input bit flip_cfg,
                      input int n_drive, output int t0);
    @(posedge CLK); #1;
    t0          = cyc;
    PAR_EN      = pen;
    PAR_TYP     = ptyp;
    cur_par_en  = pen;
    cur_par_typ = ptyp;
    model_frame(t0);
    for (int i = 0; i < line_q.size() && i < n_drive; i++) begin
      if (i > 0) begin
        @(posedge CLK); #1;
      end
      RX_IN = line_q[i];
      if (flip_cfg && i == 20) begin
        PAR_EN  = !pen;
        PAR_TYP = !ptyp;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      RX_IN = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t0, t1, saved;
    for (int c = 0; c < MAXC; c++) pd_exp[c] = '0;
    RST     = 1'b0;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    run     = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check("reset_pdata", 32'(P_DATA), 32'h0);
    check("reset_busy", 32'(Busy), 32'h0);
    RST = 1'b1;
    idle(3);

    // 8N1, 0xA5
    build(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0, 999, t0);
    idle(3);
    check("t1_dv_cycle",  32'(last_dv_cyc),   32'(t0 + 80));
    check("t1_busy_rise", 32'(busy_rise_cyc), 32'(t0 + 1));
    check("t1_busy_fall", 32'(busy_fall_cyc), 32'(t0 + 80));
    check("t1_pdata",     32'(P_DATA),        32'hA5);

    // Even parity, wrong parity bit
    saved = last_dv_cyc;
    build(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0, 999, t0);
    idle(3);
    check("t2_pe_cycle", 32'(last_pe_cyc), 32'(t0 + 88));
    check("t2_no_dv",    32'(last_dv_cyc), 32'(saved));
    check("t2_pdata",    32'(P_DATA),      32'hA5);

    // Even parity, correct bit; config toggled mid-frame must be ignored
    build(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1, 999, t0);
    idle(3);
    check("t3_dv_cycle", 32'(last_dv_cyc), 32'(t0 + 88));

    // Odd parity, 0x07 has three ones so parity bit 0
    build(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0, 999, t0);
    idle(3);
    check("t4_pdata", 32'(P_DATA), 32'h07);

    // False start: two low ticks
    line_q.delete();
    for (int k = 0; k < OS; k++) line_q.push_back(k >= 2);
    send(1'b0, 1'b0, 1'b0, 999, t0);
    idle(2);
    check("t5_false_fall", 32'(busy_fall_cyc), 32'(t0 + 8));
    build(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0, 999, t0);
    idle(3);
    check("t5_pdata", 32'(P_DATA), 32'h3C);

    // Stop bit low
    build(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 999, t0);
    idle(3);
    check("t6_se_cycle", 32'(last_se_cyc), 32'(t0 + 80));
    check("t6_pdata",    32'(P_DATA),      32'h3C);

    // Back-to-back with a mid-bit glitch in every bit
    build(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 1'b0, 1'b0, 999, t0);
    build(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 1'b0, 1'b0, 999, t1);
    idle(3);
    check("t7_gap",        32'(t1 - t0),                  32'd80);
    check("t7_dv_spacing", 32'(dv_q[$] - dv_q[$-1]),      32'd80);
    check("t7_pdata",      32'(P_DATA),                   32'hFF);

    // Reset 40 cycles into a frame, then a clean 0x81
    build(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0, 40, t0);
    @(posedge CLK); #1;
    RST   = 1'b0;
    RX_IN = 1'b1;
    model_reset(cyc);
    #1 check("t8_pdata_in_reset", 32'(P_DATA), 32'h0);
    repeat (5) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    idle(3);
    check("t8_busy_fall", 32'(busy_fall_cyc), 32'(t0 + 40));
    build(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0, 999, t0);
    idle(3);
    check("t8_dv_cycle", 32'(last_dv_cyc), 32'(t0 + 80));
    check("t8_pdata",    32'(P_DATA),      32'h81);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
